// File: rtl/weight_stream_source.sv
// weight_stream_source
//   Replays a locally stored image of convolution weights as an AXI-Stream
//   source. The weights are loaded once through a simple write port. Each
//   accepted start then streams the whole memory image cfg_reps times, with
//   tlast marking the final word of every pass.
//
// Ports
//   ap_clk                 in   clock, rising edge
//   ap_rst_n               in   asynchronous active-low reset
//   wr_en/wr_addr/wr_data  in   weight memory write port (ignored while busy)
//   cfg_reps               in   image passes per run, latched on accepted start
//   start                  in   single-cycle run request
//   busy                   out  high from accepted start until done
//   done                   out  one-cycle pulse once the final word is accepted
//   wr_err                 out  sticky flag: write attempted while busy
//   m_axis_weights_*       AXI-Stream master carrying SIMD weights per word

module weight_stream_source #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int SIMD         = 4,
  parameter int MEM_DEPTH    = 256,
  parameter int REP_WIDTH    = 16,
  localparam int DW = SIMD * WEIGHT_WIDTH,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [REP_WIDTH-1:0] cfg_reps,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err,
  output logic [DW-1:0]        m_axis_weights_tdata,
  output logic                 m_axis_weights_tvalid,
  input  logic                 m_axis_weights_tready,
  output logic                 m_axis_weights_tlast
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic [REP_WIDTH-1:0] reps_q;
  logic [REP_WIDTH-1:0] rep_cnt;
  logic [AW-1:0]        rd_addr;
  logic                 rd_active;
  logic                 inflight_v;
  logic                 inflight_last;
  logic [DW-1:0]        mem [MEM_DEPTH];
  logic [DW-1:0]        mem_q;
  logic [DW-1:0]        fifo_data [2];
  logic                 fifo_last [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic                 wr_err_q;

  logic                 start_accept, start_run, pop, push;
  logic [2:0]           occupancy;
  logic                 credit_ok, rd_issue, issue_last, final_accept;

  assign start_accept = start && (state == IDLE);
  assign start_run    = start_accept && (cfg_reps != '0);
  assign pop          = m_axis_weights_tvalid && m_axis_weights_tready;
  assign push         = inflight_v;

  // A word leaving the FIFO this cycle frees its slot, which is what lets the
  // stream run at one word per cycle despite the memory read latency.
  assign occupancy = {1'b0, count} + {2'b0, inflight_v} - {2'b0, pop};
  assign credit_ok = occupancy < 3'd2;

  // The first read is issued in the start cycle itself so that word 0 is
  // already in the FIFO two cycles after the accepted start.
  assign rd_issue   = start_run || (rd_active && credit_ok);
  assign issue_last = rd_active && (rd_addr == LAST_ADDR) &&
                      (rep_cnt == reps_q - REP_WIDTH'(1));

  // The run is finished when the last remaining word leaves and nothing more
  // is being read or is still in flight.
  assign final_accept = (state == RUN) && !rd_active && !inflight_v &&
                        (count == 2'd1) && pop;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_accept) state_next = (cfg_reps == '0) ? DONE : RUN;
      RUN:  if (final_accept) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Memory contents survive reset, so this block carries no reset.
  always_ff @(posedge ap_clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    if (rd_issue)       mem_q <= mem[rd_addr];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      reps_q        <= '0;
      rep_cnt       <= '0;
      rd_addr       <= '0;
      rd_active     <= 1'b0;
      inflight_v    <= 1'b0;
      inflight_last <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      if (start_accept) reps_q <= cfg_reps;

      if (rd_issue) begin
        if (rd_addr == LAST_ADDR) begin
          rd_addr <= '0;
          rep_cnt <= issue_last ? '0 : rep_cnt + REP_WIDTH'(1);
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
      end

      if (start_run)                    rd_active <= 1'b1;
      else if (rd_issue && issue_last)  rd_active <= 1'b0;

      inflight_v    <= rd_issue;
      inflight_last <= rd_issue && (rd_addr == LAST_ADDR);

      if (start_accept)       wr_err_q <= 1'b0;
      else if (wr_en && busy) wr_err_q <= 1'b1;
    end
  end

  // Two-entry output FIFO; tlast travels alongside each word.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign wr_err                = wr_err_q;
  assign m_axis_weights_tvalid = (count != 2'd0);
  assign m_axis_weights_tdata  = fifo_data[rd_ptr];
  assign m_axis_weights_tlast  = m_axis_weights_tvalid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_weight_stream_source.sv
// tb_weight_stream_source
//   Self-checking bench for weight_stream_source with a 4-word memory image.
//   Expected words are queued when a run is started and compared by a
//   negedge monitor whenever the stream hands a word over.

module tb_weight_stream_source;

  localparam int WW    = 8;
  localparam int SIMD  = 4;
  localparam int DEPTH = 4;
  localparam int RW    = 16;
  localparam int DW    = WW * SIMD;
  localparam int AW    = $clog2(DEPTH);

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [RW-1:0] cfg_reps = '0;
  logic          start = 1'b0;
  logic          busy, done, wr_err;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b0;

  int checks = 0;
  int failures = 0;
  int accepts = 0;

  logic [DW:0]   sb [$];
  logic [DW-1:0] model_mem [DEPTH];

  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  weight_stream_source #(
    .WEIGHT_WIDTH(WW), .SIMD(SIMD), .MEM_DEPTH(DEPTH), .REP_WIDTH(RW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cfg_reps(cfg_reps),
    .start(start),
    .busy(busy),
    .done(done),
    .wr_err(wr_err),
    .m_axis_weights_tdata(tdata),
    .m_axis_weights_tvalid(tvalid),
    .m_axis_weights_tready(tready),
    .m_axis_weights_tlast(tlast)
  );

  always #5 ap_clk = ~ap_clk;

  // Monitor: words are handed over at the posedge following a negedge where
  // tvalid and tready are both high; a stalled word must stay put.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== hold_data || tlast !== hold_last) begin
          failures++;
          $display("[TB] FAIL hold_stable: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   tvalid, tdata, tlast, hold_data, hold_last);
        end
      end
      if (tvalid === 1'b1 && tready === 1'b1) begin
        checks++;
        accepts++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL stream_word: got data=%h last=%b, need no word", tdata, tlast);
        end else begin
          logic [DW:0] exp;
          exp = sb.pop_front();
          if ({tlast, tdata} !== exp) begin
            failures++;
            $display("[TB] FAIL stream_word: got data=%h last=%b, need data=%h last=%b",
                     tdata, tlast, exp[DW-1:0], exp[DW]);
          end
        end
      end
      hold_pending = (tvalid === 1'b1) && (tready !== 1'b1);
      hold_data    = tdata;
      hold_last    = tlast;
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic load_mem(input bit use_random);
    for (int a = 0; a < DEPTH; a++) begin
      logic [DW-1:0] v;
      v = use_random ? DW'($urandom) : DW'(a);
      model_mem[a] = v;
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = v;
      step();
    end
    wr_en = 1'b0;
  endtask

  // Queues the expected image passes, then pulses start; returns in cycle T+1.
  task automatic pulse_start(input int reps);
    for (int r = 0; r < reps; r++)
      for (int a = 0; a < DEPTH; a++)
        sb.push_back({(a == DEPTH - 1), model_mem[a]});
    cfg_reps = RW'(reps);
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, wr_err, tvalid, tlast} !== 5'b0 || tdata !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b wr_err=%b valid=%b last=%b data=%h, need all 0",
               busy, done, wr_err, tvalid, tlast, tdata);
    end
    step();
    step();
    ap_rst_n = 1'b1;
    step();
    checks++;
    if ({busy, done, tvalid} !== 3'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b valid=%b, need 000", busy, done, tvalid);
    end
  endtask

  task automatic test_basic();
    int base;
    load_mem(1'b0);
    tready = 1'b1;
    base = accepts;
    pulse_start(2);
    checks++;
    if (busy !== 1'b1 || tvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_t1: got busy=%b valid=%b, need busy=1 valid=0", busy, tvalid);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tvalid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL basic_no_gap: word %0d got valid=%b, need 1", i, tvalid);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || tvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done: got done=%b busy=%b valid=%b, need 1 1 0", done, busy, tvalid);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_idle: got done=%b busy=%b, need 0 0", done, busy);
    end
    checks++;
    if (accepts - base != 8 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d accepts, %0d left, need 8, 0", accepts - base, sb.size());
    end
  endtask

  task automatic test_toggle_ready();
    int base;
    load_mem(1'b1);
    tready = 1'b1;
    base = accepts;
    pulse_start(2);
    for (int c = 0; c < 40 && accepts - base < 8; c++) begin
      tready = ~tready;
      step();
    end
    tready = 1'b1;
    for (int i = 0; i < 5 && done !== 1'b1; i++) step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL toggle_done: got done=%b, need 1", done);
    end
    step();
    checks++;
    if (accepts - base != 8 || sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL toggle_count: got %0d accepts, %0d left, busy=%b, need 8, 0, 0",
               accepts - base, sb.size(), busy);
    end
  endtask

  task automatic test_stall();
    int base;
    load_mem(1'b1);
    tready = 1'b0;
    base = accepts;
    pulse_start(2);
    step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== model_mem[0]) begin
        failures++;
        $display("[TB] FAIL stall_hold: got valid=%b data=%h, need 1 %h", tvalid, tdata, model_mem[0]);
      end
      step();
    end
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tvalid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_no_gap: word %0d got valid=%b, need 1", i, tvalid);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || accepts - base != 8) begin
      failures++;
      $display("[TB] FAIL stall_done: got done=%b accepts=%0d, need 1 8", done, accepts - base);
    end
    step();
  endtask

  task automatic test_zero_reps();
    tready = 1'b1;
    pulse_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || tvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b valid=%b, need 1 1 0", done, busy, tvalid);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_idle: got done=%b busy=%b, need 0 0", done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL zero_no_word: got valid=%b, need 0", tvalid);
      end
      step();
    end
  endtask

  task automatic test_write_while_busy();
    load_mem(1'b0);
    tready = 1'b0;
    pulse_start(1);
    wr_en    = 1'b1;
    wr_addr  = AW'(1);
    wr_data  = DW'(32'hFF);
    cfg_reps = RW'(3);
    start    = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    checks++;
    if (wr_err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrerr_set: got wr_err=%b busy=%b, need 1 1", wr_err, busy);
    end
    tready = 1'b1;
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrerr_run_done: got done=%b left=%0d, need 1 0", done, sb.size());
    end
    step();
    step();
    checks++;
    if (wr_err !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrerr_sticky: got wr_err=%b valid=%b busy=%b, need 1 0 0", wr_err, tvalid, busy);
    end
    pulse_start(1);
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrerr_clear: got wr_err=%b, need 0", wr_err);
    end
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrerr_rerun: got done=%b left=%0d, need 1 0", done, sb.size());
    end
    step();
  endtask

  task automatic test_mid_reset();
    int base;
    tready = 1'b1;
    base = accepts;
    pulse_start(2);
    for (int i = 0; i < 20 && accepts - base < 3; i++) step();
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({tvalid, busy, done} !== 3'b0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got valid=%b busy=%b done=%b, need 000", tvalid, busy, done);
    end
    sb.delete();
    step();
    step();
    ap_rst_n = 1'b1;
    step();
    checks++;
    if ({tvalid, busy, done} !== 3'b0) begin
      failures++;
      $display("[TB] FAIL midrst_wait: got valid=%b busy=%b done=%b, need 000", tvalid, busy, done);
    end
    pulse_start(1);
    step();
    checks++;
    if (tvalid !== 1'b1 || tdata !== model_mem[0]) begin
      failures++;
      $display("[TB] FAIL midrst_restart: got valid=%b data=%h, need 1 %h", tvalid, tdata, model_mem[0]);
    end
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL midrst_done: got done=%b left=%0d, need 1 0", done, sb.size());
    end
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle_ready();
    test_stall();
    test_zero_reps();
    test_write_while_busy();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
